// File: rtl/cmp_arb_pkg.sv
// Shared types and constants for the two-requester comparator arbiter.
package cmp_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      RESP    = 2'd2
   } state_t;

   localparam int CMP_WIDTH = 2;
   localparam int STAT_W    = 8;

   // Counter increment that holds at all-ones instead of wrapping.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] val);
      sat_inc = (val == {STAT_W{1'b1}}) ? val : val + 1'b1;
   endfunction

endpackage

// File: rtl/comparator.sv
// Unsigned magnitude comparator; the single datapath shared by both requesters.
module comparator
   import cmp_arb_pkg::*;
(
   input  logic [CMP_WIDTH-1:0] A,
   input  logic [CMP_WIDTH-1:0] B,
   output logic                 less,
   output logic                 equal,
   output logic                 greater
);

   assign less    = (A <  B);
   assign equal   = (A == B);
   assign greater = (A >  B);

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter feeding a shared comparator; one request in flight at a time.
// Optional per-requester response counters are built when CMP_ARBITER_STATS_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a valid request; grants one and latches its operands
// COMPARE | latched operands on the comparator; flags registered at exit
// RESP    | result strobed out on the following cycle; last-grant updated
module cmp_arbiter
   import cmp_arb_pkg::*;
#(
   parameter int WIDTH = CMP_WIDTH
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [WIDTH-1:0]  req0_a,
   input  logic [WIDTH-1:0]  req0_b,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [WIDTH-1:0]  req1_a,
   input  logic [WIDTH-1:0]  req1_b,
   output logic              req1_ready,
   output logic              rsp_valid,
   output logic              rsp_id,
   output logic              rsp_less,
   output logic              rsp_equal,
   output logic              rsp_greater,
   output logic [STAT_W-1:0] stat0_cnt,
   output logic [STAT_W-1:0] stat1_cnt
);

   state_t           r_state;
   logic             r_last;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_id;
   logic             r_cmp_less;
   logic             r_cmp_equal;
   logic             r_cmp_greater;
   logic             r_rsp_valid;
   logic             r_rsp_id;
   logic             r_rsp_less;
   logic             r_rsp_equal;
   logic             r_rsp_greater;

   logic             w_idle;
   logic             w_grant0;
   logic             w_grant1;
   logic             w_less;
   logic             w_equal;
   logic             w_greater;

   // On a tie the requester that did not win last time gets the grant.
   assign w_idle   = (r_state == IDLE);
   assign w_grant0 = w_idle && req0_valid && (!req1_valid || r_last);
   assign w_grant1 = w_idle && req1_valid && (!req0_valid || !r_last);

   assign req0_ready = w_grant0;
   assign req1_ready = w_grant1;

   comparator u_cmp (
      .A       (r_a),
      .B       (r_b),
      .less    (w_less),
      .equal   (w_equal),
      .greater (w_greater)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_last        <= 1'b1;
         r_a           <= '0;
         r_b           <= '0;
         r_id          <= 1'b0;
         r_cmp_less    <= 1'b0;
         r_cmp_equal   <= 1'b0;
         r_cmp_greater <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_id      <= 1'b0;
         r_rsp_less    <= 1'b0;
         r_rsp_equal   <= 1'b0;
         r_rsp_greater <= 1'b0;
      end else begin
         // Response outputs are a one-cycle strobe and read zero otherwise.
         r_rsp_valid   <= 1'b0;
         r_rsp_id      <= 1'b0;
         r_rsp_less    <= 1'b0;
         r_rsp_equal   <= 1'b0;
         r_rsp_greater <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_grant0 || w_grant1) begin
                  r_a     <= w_grant1 ? req1_a : req0_a;
                  r_b     <= w_grant1 ? req1_b : req0_b;
                  r_id    <= w_grant1;
                  r_state <= COMPARE;
               end
            end
            COMPARE: begin
               r_cmp_less    <= w_less;
               r_cmp_equal   <= w_equal;
               r_cmp_greater <= w_greater;
               r_state       <= RESP;
            end
            RESP: begin
               r_rsp_valid   <= 1'b1;
               r_rsp_id      <= r_id;
               r_rsp_less    <= r_cmp_less;
               r_rsp_equal   <= r_cmp_equal;
               r_rsp_greater <= r_cmp_greater;
               r_last        <= r_id;
               r_state       <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rsp_valid   = r_rsp_valid;
   assign rsp_id      = r_rsp_id;
   assign rsp_less    = r_rsp_less;
   assign rsp_equal   = r_rsp_equal;
   assign rsp_greater = r_rsp_greater;

`ifdef CMP_ARBITER_STATS_EN
   logic [STAT_W-1:0] r_stat0;
   logic [STAT_W-1:0] r_stat1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat0 <= '0;
         r_stat1 <= '0;
      end else if (r_state == RESP) begin
         if (r_id) r_stat1 <= sat_inc(r_stat1);
         else      r_stat0 <= sat_inc(r_stat0);
      end
   end

   assign stat0_cnt = r_stat0;
   assign stat1_cnt = r_stat1;
`else
   assign stat0_cnt = '0;
   assign stat1_cnt = '0;
`endif

endmodule

// File: tb/tb_cmp_arbiter.sv
// Randomized and directed bench for cmp_arbiter against a response-schedule model.
module tb_cmp_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid = 1'b0;
   logic [1:0] req0_a = '0;
   logic [1:0] req0_b = '0;
   logic       req0_ready;
   logic       req1_valid = 1'b0;
   logic [1:0] req1_a = '0;
   logic [1:0] req1_b = '0;
   logic       req1_ready;
   logic       rsp_valid;
   logic       rsp_id;
   logic       rsp_less;
   logic       rsp_equal;
   logic       rsp_greater;
   logic [7:0] stat0_cnt;
   logic [7:0] stat1_cnt;

   cmp_arbiter #(.WIDTH(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .req0_valid  (req0_valid),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req0_ready  (req0_ready),
      .req1_valid  (req1_valid),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .req1_ready  (req1_ready),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_less    (rsp_less),
      .rsp_equal   (rsp_equal),
      .rsp_greater (rsp_greater),
      .stat0_cnt   (stat0_cnt),
      .stat1_cnt   (stat1_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int   cyc;
      logic id;
      logic lt;
      logic eq;
      logic gt;
   } rsp_t;

   rsp_t q_rsp[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc      = 0;
   int   free_at  = 0;
   logic m_last   = 1'b1;
   int   m_stat0  = 0;
   int   m_stat1  = 0;
   int   n_lt = 0, n_eq = 0, n_gt = 0;
   int   n_grant0 = 0, n_grant1 = 0;
   logic stats_en;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, then advance the model.
   task automatic step(input logic v0, input logic [1:0] a0, input logic [1:0] b0,
                       input logic v1, input logic [1:0] a1, input logic [1:0] b1,
                       input logic r);
      logic g0, g1, idle, ev, eid, elt, eeq, egt, id;
      logic [1:0] a, b;
      rsp_t e;
      @(negedge clk);
      rst = r;
      req0_valid = v0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_a = a1; req1_b = b1;
      #1;
      idle = (cyc >= free_at);
      g0 = idle && v0 && (!v1 || m_last);
      g1 = idle && v1 && (!v0 || !m_last);
      check("req0_ready", req0_ready, g0);
      check("req1_ready", req1_ready, g1);
      ev = 0; eid = 0; elt = 0; eeq = 0; egt = 0;
      if (q_rsp.size() > 0 && q_rsp[0].cyc == cyc) begin
         e = q_rsp.pop_front();
         ev = 1; eid = e.id; elt = e.lt; eeq = e.eq; egt = e.gt;
         if (stats_en) begin
            if (e.id) m_stat1 = (m_stat1 < 255) ? m_stat1 + 1 : 255;
            else      m_stat0 = (m_stat0 < 255) ? m_stat0 + 1 : 255;
         end
      end
      check("rsp_valid", rsp_valid, ev);
      check("rsp_id", rsp_id, eid);
      check("rsp_less", rsp_less, elt);
      check("rsp_equal", rsp_equal, eeq);
      check("rsp_greater", rsp_greater, egt);
      check("stat0_cnt", stat0_cnt, m_stat0);
      check("stat1_cnt", stat1_cnt, m_stat1);
      if (rsp_valid) begin
         if (rsp_less)    n_lt++;
         if (rsp_equal)   n_eq++;
         if (rsp_greater) n_gt++;
      end
      if (r) begin
         q_rsp.delete();
         m_last  = 1'b1;
         free_at = 0;
         m_stat0 = 0;
         m_stat1 = 0;
      end else if (g0 || g1) begin
         id = g1;
         a  = id ? a1 : a0;
         b  = id ? b1 : b0;
         q_rsp.push_back('{cyc + 3, id, a < b, a == b, a > b});
         free_at = cyc + 3;
         m_last  = id;
         if (id) n_grant1++; else n_grant0++;
      end
      cyc++;
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
`ifdef CMP_ARBITER_STATS_EN
      stats_en = 1'b1;
`else
      stats_en = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_ready0", req0_ready, 0);
      check("reset_stat0", stat0_cnt, 0);

      // req0 alone: 1 < 2, response three cycles after the handshake cycle
      n_lt = 0;
      step(1, 2'b01, 2'b10, 0, 0, 0, 0);
      idle_steps(4);
      check("single_less_count", n_lt, 1);

      // both held: alternating equal (id0) / greater (id1)
      n_grant0 = 0; n_grant1 = 0; n_eq = 0; n_gt = 0;
      for (int i = 0; i < 24; i++) step(1, 2'd3, 2'd3, 1, 2'd3, 2'd0, 0);
      idle_steps(4);
      check("rr_grant0", n_grant0, 4);
      check("rr_grant1", n_grant1, 4);
      check("rr_equal", n_eq, 4);
      check("rr_greater", n_gt, 4);

      // exhaustive operand pairs through requester 1
      n_lt = 0; n_eq = 0; n_gt = 0;
      for (int p = 0; p < 16; p++) begin
         step(0, 0, 0, 1, p[3:2], p[1:0], 0);
         idle_steps(2);
      end
      idle_steps(2);
      check("all_less", n_lt, 6);
      check("all_equal", n_eq, 4);
      check("all_greater", n_gt, 6);

      // reset while in COMPARE abandons the request; tie afterwards goes to 0
      step(0, 0, 0, 1, 2'd0, 2'd1, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      n_lt = 0;
      idle_steps(4);
      check("abandoned_no_rsp", n_lt, 0);
      n_grant0 = 0;
      step(1, 2'd1, 2'd1, 1, 2'd2, 2'd1, 0);
      check("post_reset_tie_grant0", n_grant0, 1);
      idle_steps(3);

      // operands change right after handshake
      n_lt = 0; n_gt = 0;
      step(1, 2'd0, 2'd3, 0, 0, 0, 0);
      step(0, 2'd3, 2'd0, 0, 0, 0, 0);
      idle_steps(3);
      check("late_change_less", n_lt, 1);
      check("late_change_greater", n_gt, 0);

      // randomized traffic, including valids that drop before grant
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 1), 2'($urandom), 2'($urandom),
              $urandom_range(0, 1), 2'($urandom), 2'($urandom), 0);
      idle_steps(4);

      // counter saturation: fresh reset, then 300 requester-0 responses
      step(0, 0, 0, 0, 0, 0, 1);
      n_grant0 = 0;
      for (int i = 0; i < 900; i++) step(1, 2'($urandom), 2'($urandom), 0, 0, 0, 0);
      idle_steps(4);
      check("sat_grants", n_grant0, 300);
      check("sat_stat0", stat0_cnt, stats_en ? 255 : 0);
      check("sat_stat1", stat1_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
